// File: rtl/mux_barrido_pkg.sv
// mux_barrido_pkg: shared state encoding and mode constants for the scanning multiplexer.
package mux_barrido_pkg;
  typedef enum logic [1:0] {INACTIVO, MANUAL, BARRIDO} estado_t;
  localparam logic MODO_MANUAL  = 1'b0;
  localparam logic MODO_BARRIDO = 1'b1;
endpackage

// File: rtl/cont_permanencia.sv
// cont_permanencia: dwell counter that wraps at PERMANENCIA-1 and flags the terminal count.
module cont_permanencia #(
  parameter int PERMANENCIA = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc
);
  localparam int CW = PERMANENCIA > 1 ? $clog2(PERMANENCIA) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tc = cnt_q == CW'(PERMANENCIA - 1);
  always_comb cnt_d = (clr || tc) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/mux_barrido.sv
// mux_barrido: N-channel registered mux with manual select and round-robin scan mode.
// Define MUX_MASCARA_EN to let mascara skip channels during the scan.
module mux_barrido
  import mux_barrido_pkg::*;
#(
  parameter  int N_CANALES   = 4,
  parameter  int ANCHO       = 1,
  parameter  int PERMANENCIA = 4,
  localparam int SW          = $clog2(N_CANALES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CANALES*ANCHO-1:0] w,
  input  logic [SW-1:0]              sel,
  input  logic                       modo,
  input  logic                       habilitar,
  input  logic [N_CANALES-1:0]       mascara,
  output logic [ANCHO-1:0]           f,
  output logic [SW-1:0]              sel_actual,
  output logic                       valido,
  output logic                       fin_barrido
);
  estado_t state_q, state_d;
  logic [ANCHO-1:0] f_q, f_d;
  logic [SW-1:0] sel_q, sel_d, sig, primero;
  logic valido_q, valido_d, fin_q, fin_d;
  logic entra, clr, tc, hay, envuelve;
  logic [N_CANALES-1:0] mask_eff;
`ifdef MUX_MASCARA_EN
  assign mask_eff = mascara;
`else
  logic unused_mascara;
  assign mask_eff = '1;
  assign unused_mascara = ^mascara;
`endif
  assign hay = |mask_eff;
  cont_permanencia #(.PERMANENCIA(PERMANENCIA)) u_cont (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tc    (tc)
  );
  // Nearest enabled channel above the current one (searching downward so the closest wins) and the lowest enabled one.
  always_comb begin
    sig = sel_q;
    envuelve = 1'b0;
    primero = '0;
    for (int i = N_CANALES; i >= 1; i--) begin
      if (mask_eff[(int'(sel_q) + i) % N_CANALES]) begin
        sig = SW'((int'(sel_q) + i) % N_CANALES);
        envuelve = int'(sel_q) + i >= N_CANALES;
      end
    end
    for (int i = N_CANALES - 1; i >= 0; i--)
      if (mask_eff[i]) primero = SW'(i);
  end
  always_comb begin
    state_d = !habilitar ? INACTIVO : (modo == MODO_BARRIDO ? BARRIDO : MANUAL);
    entra = state_d == BARRIDO && state_q != BARRIDO;
    clr = state_d != BARRIDO || entra;
    sel_d = sel_q;
    f_d = f_q;
    valido_d = 1'b0;
    fin_d = 1'b0;
    if (state_d == MANUAL) begin
      sel_d = sel;
      valido_d = int'(sel) < N_CANALES;
      f_d = valido_d ? w[int'(sel)*ANCHO +: ANCHO] : '0;
    end else if (state_d == BARRIDO && hay) begin
      sel_d = entra ? primero : (tc ? sig : sel_q);
      fin_d = !entra && tc && envuelve;
      valido_d = 1'b1;
      f_d = w[int'(sel_d)*ANCHO +: ANCHO];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= INACTIVO;
      f_q      <= '0;
      sel_q    <= '0;
      valido_q <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      f_q      <= f_d;
      sel_q    <= sel_d;
      valido_q <= valido_d;
      fin_q    <= fin_d;
    end
  assign f           = f_q;
  assign sel_actual  = sel_q;
  assign valido      = valido_q;
  assign fin_barrido = fin_q;
endmodule

// File: tb/tb_mux_barrido.sv
// tb_mux_barrido: directed and random checks of mux_barrido against a cycle-count reference model.
module tb_mux_barrido;
  localparam int N = 4, A = 8, P = 2, SW = 2;
  localparam logic [N*A-1:0] W_FIJO = {8'h44, 8'h33, 8'h22, 8'h11};
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N*A-1:0] w = W_FIJO;
  logic [SW-1:0] sel = '0;
  logic modo = 1'b0, hab = 1'b0;
  logic [N-1:0] mascara = '1;
  logic [A-1:0] f;
  logic [SW-1:0] sel_actual;
  logic valido, fin_barrido;
  int errors = 0, checks = 0;
  logic [A-1:0] m_f = '0;
  int m_sel = 0, k = -1;
  logic m_val = 1'b0, m_fin = 1'b0;
  int exp_seq[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  int exp_msk[6] = '{1, 1, 3, 3, 1, 1};

  always #5 clk = ~clk;

  mux_barrido #(.N_CANALES(N), .ANCHO(A), .PERMANENCIA(P)) dut (
    .clk(clk), .rst_n(rst_n), .w(w), .sel(sel), .modo(modo), .habilitar(hab),
    .mascara(mascara), .f(f), .sel_actual(sel_actual), .valido(valido), .fin_barrido(fin_barrido)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_f = '0; m_sel = 0; m_val = 1'b0; m_fin = 1'b0; k = -1;
  endtask

  // k counts edges since entering scan; channel and wrap follow directly from it.
  task automatic model_edge();
    if (!hab) begin
      m_val = 1'b0; m_fin = 1'b0; k = -1;
    end else if (!modo) begin
      m_sel = int'(sel); m_f = w[int'(sel)*A +: A]; m_val = 1'b1; m_fin = 1'b0; k = -1;
    end else begin
      k = k + 1;
      m_sel = (k / P) % N;
      m_f = w[m_sel*A +: A];
      m_val = 1'b1;
      m_fin = (k > 0) && (k % (P * N) == 0);
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, ".f"}, 32'(f), 32'(m_f));
    chk({tag, ".sel"}, 32'(sel_actual), 32'(m_sel));
    chk({tag, ".valido"}, 32'(valido), 32'(m_val));
    chk({tag, ".fin"}, 32'(fin_barrido), 32'(m_fin));
  endtask

  initial begin
    #12;
    chk("rst.f", 32'(f), 0);
    chk("rst.sel", 32'(sel_actual), 0);
    chk("rst.valido", 32'(valido), 0);
    chk("rst.fin", 32'(fin_barrido), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("idle");
    hab = 1'b1;
    for (int s = 0; s < N; s++) begin
      sel = SW'(s);
      step("manual");
      chk("manual.const", 32'(f), 32'((s + 1) * 8'h11));
    end
    modo = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step("scan");
      chk("scan.seq", 32'(sel_actual), 32'(exp_seq[i]));
      chk("scan.finpos", 32'(fin_barrido), 32'(i == 8));
    end
    for (int n = 0; n < 20 && sel_actual !== 2'd2; n++) step("seek");
    chk("seek.reach2", 32'(sel_actual), 2);
    hab = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("off");
      chk("off.f33", 32'(f), 32'h33);
      chk("off.valido", 32'(valido), 0);
    end
    hab = 1'b1;
    step("reen");
    chk("reen.sel0", 32'(sel_actual), 0);
    chk("reen.f11", 32'(f), 32'h11);
    for (int i = 0; i < 5; i++) step("prerst");
    #2 rst_n = 1'b0;
    #1;
    chk("arst.f", 32'(f), 0);
    chk("arst.sel", 32'(sel_actual), 0);
    chk("arst.valido", 32'(valido), 0);
    chk("arst.fin", 32'(fin_barrido), 0);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      hab = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) modo = ~modo;
      sel = SW'($urandom);
      w = {$urandom, $urandom} & {N*A{1'b1}};
`ifndef MUX_MASCARA_EN
      mascara = N'($urandom);
`endif
      step("rand");
    end
`ifdef MUX_MASCARA_EN
    w = W_FIJO;
    mascara = 4'b1010;
    modo = 1'b0;
    hab = 1'b1;
    @(posedge clk);
    #1;
    modo = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("mask.seq", 32'(sel_actual), 32'(exp_msk[i]));
      chk("mask.fin", 32'(fin_barrido), 32'(i == 4));
      chk("mask.f", 32'(f), 32'((exp_msk[i] + 1) * 8'h11));
    end
    mascara = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("mask0.valido", 32'(valido), 0);
      chk("mask0.sel", 32'(sel_actual), 1);
      chk("mask0.f", 32'(f), 32'h22);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux_barrido.md
# mux_barrido

Parametrised N-channel multiplexer with registered output and an automatic channel-scan mode; the next generation of the team's combinational 4:1 selector. Selects one of `N_CANALES` input words of `ANCHO` bits either from an external selector (manual) or by stepping round-robin through the channels, dwelling `PERMANENCIA` cycles on each. Sits between parallel sensor/data sources and a single shared downstream consumer (display, serialiser, logger).

## Interface
- `N_CANALES`, 4: number of input channels, ≥2.
- `ANCHO`, 1: bits per channel, ≥1.
- `PERMANENCIA`, 4: dwell cycles per channel in scan mode, ≥1.
- `SW` (localparam): `$clog2(N_CANALES)`.

- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `w`  in  N_CANALES*ANCHO  flattened inputs; channel k at `[k*ANCHO +: ANCHO]`.
- `sel`  in  SW  manual channel select.
- `modo`  in  1  0 = manual, 1 = scan.
- `habilitar`  in  1  block enable.
- `mascara`  in  N_CANALES  per-channel scan enable (used only with macro, see Configuration).
- `f`  out  ANCHO  registered selected word.
- `sel_actual`  out  SW  channel currently driving `f`.
- `valido`  out  1  `f` holds a legal channel's data.
- `fin_barrido`  out  1  one-cycle pulse on scan wrap-around.

## Operation
- Reset: state INACTIVO; `f`=0, `sel_actual`=0, `valido`=0, `fin_barrido`=0, dwell counter=0.
- States: INACTIVO, MANUAL, BARRIDO. Transitions are evaluated every edge:
  - `habilitar`=0 → INACTIVO (from any state);
  - `habilitar`=1, `modo`=0 → MANUAL;
  - `habilitar`=1, `modo`=1 → BARRIDO.
- INACTIVO: `f` and `sel_actual` hold their last values; `valido`=0; dwell counter cleared.
- MANUAL: each edge `sel_actual`←`sel`, `f`←channel `sel`, `valido`=1. If `sel`≥`N_CANALES` (non-power-of-2 N), then `f`←0 and `valido`=0.
- BARRIDO:
  - On entry from another state: `sel_actual`←0, `f`←w[0], dwell counter←0.
  - Afterwards the dwell counter increments each cycle. When it reaches `PERMANENCIA-1`, it clears and `sel_actual` advances to the next channel; `f` is re-sampled every edge from the current `sel_actual`. `valido`=1.
  - Wrap: advancing from `N_CANALES-1` to 0 asserts `fin_barrido` for exactly the cycle in which `sel_actual`=0 first appears. Entry into BARRIDO does not pulse it.
  - `PERMANENCIA`=1: a new channel every cycle.
- Mode change mid-scan (BARRIDO→MANUAL): takes effect at the next edge; scan position is discarded.

## Timing
- Latency 1 cycle: inputs sampled at edge t appear on `f`/`sel_actual`/`valido` after edge t.
- `f` and `sel_actual` always update on the same edge, so they are always consistent.
- Async reset mid-scan clears all outputs immediately, independent of `clk`.
- `fin_barrido` is registered and never lasts more than 1 cycle.

## Configuration
- `MUX_MASCARA_EN` defined: in BARRIDO, channels with `mascara[k]`=0 are skipped.
  - Advance goes to the next channel above the current one with its mask bit set, wrapping around; `fin_barrido` pulses when the index wraps.
  - Entry starts at the lowest enabled channel.
  - All mask bits 0: `valido`=0, `sel_actual` and `f` hold.
  - Mask changes are sampled at each advance.
- Not defined: `mascara` is ignored and every channel is scanned.

## Structure
- Package `mux_barrido_pkg`: state enum (INACTIVO, MANUAL, BARRIDO) and the `MODO_MANUAL`/`MODO_BARRIDO` constants.
- Sub-module `cont_permanencia`: parametrised dwell counter with clear input and a terminal-count output; instantiated once.

## Test plan
All scenarios use N=4, ANCHO=8, PERMANENCIA=2, w={8'h44,8'h33,8'h22,8'h11}.
- Reset, then hold `habilitar`=0 for 5 cycles → `f`=0, `valido`=0, `sel_actual`=0 throughout.
- MANUAL, `sel` stepped 0..3, one value per cycle → `f`=11,22,33,44 one cycle after each `sel`; `valido`=1.
- BARRIDO for 10 cycles → `sel_actual` 0,0,1,1,2,2,3,3,0,0; `fin_barrido` high only at the second occurrence of 0.
- Drop `habilitar` while `sel_actual`=2 in BARRIDO, re-enable 3 cycles later → `valido`=0 and `f`=33 held while disabled; scan restarts at channel 0.
- Assert `rst_n`=0 mid-cycle during BARRIDO → all outputs go to 0 without waiting for a clock edge.
- With `MUX_MASCARA_EN` and `mascara`=4'b1010 → `sel_actual` 1,1,3,3,1…, with `fin_barrido` on each return to 1. Then `mascara`=0 → `valido`=0 and outputs hold.
